// File: rtl/ips2l_pcie_dma_req_splitter.sv
// Splits one DMA transfer command into MPS/MRRS-sized MWr/MRd requests for the PCIe TX top.
// Define IPS2L_PCIE_DMA_4K_SPLIT_EN to also keep every chunk inside one 4 KB address page.
//
// state | meaning
// IDLE  | ready for a command
// CALC  | register next chunk size and 32/64 variant
// HOLD  | chunk ready, waiting for write-busy / tag-full to clear
// REQ   | one request held high until its own ack
// DONE  | one-cycle completion pulse
module ips2l_pcie_dma_req_splitter #(
    parameter int CMD_LEN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               i_cfg_max_payload_size,
    input  logic [2:0]               i_cfg_max_rd_req_size,
    input  logic                     i_cmd_vld,
    output logic                     o_cmd_rdy,
    input  logic                     i_cmd_wr,
    input  logic [63:0]              i_cmd_addr,
    input  logic [CMD_LEN_WIDTH-1:0] i_cmd_len,
    output logic                     o_cmd_done,
    output logic                     o_busy,
    output logic                     o_mwr32_req,
    input  logic                     i_mwr32_req_ack,
    output logic                     o_mwr64_req,
    input  logic                     i_mwr64_req_ack,
    output logic                     o_mrd32_req,
    input  logic                     i_mrd32_req_ack,
    output logic                     o_mrd64_req,
    input  logic                     i_mrd64_req_ack,
    output logic [9:0]               o_req_length,
    output logic [63:0]              o_req_addr,
    input  logic                     i_mwr_tx_busy,
    input  logic                     i_tag_full
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_REQ  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [63:0]              addr_q, addr_d;
    logic [CMD_LEN_WIDTH-1:0] rem_q, rem_d;
    logic                     wr_q, wr_d;
    logic [2:0]               enc_q, enc_d;
    logic [10:0]              chunk_q, chunk_d;
    logic                     is64_q, is64_d;
    logic                     rdy_q, rdy_d;

    logic [2:0]               enc_eff;
    logic [10:0]              max_dw;
    logic [10:0]              rem_cap;
    logic [10:0]              span_dw;
    logic [10:0]              chunk_calc;
    logic [31:0]              rem_ext;
    logic [CMD_LEN_WIDTH-1:0] rem_next;
    logic                     gate;
    logic                     ack;

    always_comb begin
        enc_eff = (enc_q > 3'd5) ? 3'd0 : enc_q;
        max_dw  = 11'd32 << enc_eff;
        rem_ext = 32'(rem_q);
        rem_cap = (rem_ext >= 32'd1024) ? 11'd1024 : rem_ext[10:0];
`ifdef IPS2L_PCIE_DMA_4K_SPLIT_EN
        span_dw = 11'd1024 - {1'b0, addr_q[11:2]};
`else
        span_dw = 11'd1024;
`endif
        chunk_calc = (rem_cap < max_dw) ? rem_cap : max_dw;
        if (span_dw < chunk_calc) begin
            chunk_calc = span_dw;
        end
        gate     = wr_q ? i_mwr_tx_busy : i_tag_full;
        // only the ack matching the currently asserted request counts
        ack      = wr_q ? (is64_q ? i_mwr64_req_ack : i_mwr32_req_ack)
                        : (is64_q ? i_mrd64_req_ack : i_mrd32_req_ack);
        rem_next = rem_q - CMD_LEN_WIDTH'(chunk_q);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wr_d    = wr_q;
        enc_d   = enc_q;
        chunk_d = chunk_q;
        is64_d  = is64_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_vld && rdy_q) begin
                    addr_d  = i_cmd_addr & ~64'h3;
                    rem_d   = i_cmd_len;
                    wr_d    = i_cmd_wr;
                    enc_d   = i_cmd_wr ? i_cfg_max_payload_size : i_cfg_max_rd_req_size;
                    state_d = (i_cmd_len == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                chunk_d = chunk_calc;
                is64_d  = |addr_q[63:32];
                state_d = gate ? ST_HOLD : ST_REQ;
            end
            ST_HOLD: begin
                if (!gate) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    addr_d  = addr_q + {51'd0, chunk_q, 2'b00};
                    rem_d   = rem_next;
                    state_d = (rem_next == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // ready is registered so it stays low through the reset cycle
        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            wr_q    <= 1'b0;
            enc_q   <= '0;
            chunk_q <= '0;
            is64_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            enc_q   <= enc_d;
            chunk_q <= chunk_d;
            is64_q  <= is64_d;
            rdy_q   <= rdy_d;
        end
    end

    assign o_cmd_rdy    = rdy_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_cmd_done   = (state_q == ST_DONE);
    assign o_mwr32_req  = (state_q == ST_REQ) &  wr_q & ~is64_q;
    assign o_mwr64_req  = (state_q == ST_REQ) &  wr_q &  is64_q;
    assign o_mrd32_req  = (state_q == ST_REQ) & ~wr_q & ~is64_q;
    assign o_mrd64_req  = (state_q == ST_REQ) & ~wr_q &  is64_q;
    assign o_req_length = chunk_q[9:0];
    assign o_req_addr   = addr_q;

endmodule

// File: tb/tb_ips2l_pcie_dma_req_splitter.sv
// Directed bench for ips2l_pcie_dma_req_splitter; expectations follow IPS2L_PCIE_DMA_4K_SPLIT_EN.
module tb_ips2l_pcie_dma_req_splitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  i_cfg_max_payload_size = 3'd0;
    logic [2:0]  i_cfg_max_rd_req_size = 3'd0;
    logic        i_cmd_vld = 1'b0;
    logic        o_cmd_rdy;
    logic        i_cmd_wr = 1'b0;
    logic [63:0] i_cmd_addr = '0;
    logic [15:0] i_cmd_len = '0;
    logic        o_cmd_done;
    logic        o_busy;
    logic        o_mwr32_req, o_mwr64_req, o_mrd32_req, o_mrd64_req;
    logic        i_mwr32_req_ack = 1'b0, i_mwr64_req_ack = 1'b0;
    logic        i_mrd32_req_ack = 1'b0, i_mrd64_req_ack = 1'b0;
    logic [9:0]  o_req_length;
    logic [63:0] o_req_addr;
    logic        i_mwr_tx_busy = 1'b0;
    logic        i_tag_full = 1'b0;
    logic [3:0]  reqvec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign reqvec = {o_mrd64_req, o_mrd32_req, o_mwr64_req, o_mwr32_req};

    ips2l_pcie_dma_req_splitter #(.CMD_LEN_WIDTH(16)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_cfg_max_payload_size (i_cfg_max_payload_size),
        .i_cfg_max_rd_req_size  (i_cfg_max_rd_req_size),
        .i_cmd_vld              (i_cmd_vld),
        .o_cmd_rdy              (o_cmd_rdy),
        .i_cmd_wr               (i_cmd_wr),
        .i_cmd_addr             (i_cmd_addr),
        .i_cmd_len              (i_cmd_len),
        .o_cmd_done             (o_cmd_done),
        .o_busy                 (o_busy),
        .o_mwr32_req            (o_mwr32_req),
        .i_mwr32_req_ack        (i_mwr32_req_ack),
        .o_mwr64_req            (o_mwr64_req),
        .i_mwr64_req_ack        (i_mwr64_req_ack),
        .o_mrd32_req            (o_mrd32_req),
        .i_mrd32_req_ack        (i_mrd32_req_ack),
        .o_mrd64_req            (o_mrd64_req),
        .i_mrd64_req_ack        (i_mrd64_req_ack),
        .o_req_length           (o_req_length),
        .o_req_addr             (o_req_addr),
        .i_mwr_tx_busy          (i_mwr_tx_busy),
        .i_tag_full             (i_tag_full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [63:0] addr, input logic [15:0] len);
        int n = 0;
        @(negedge clk);
        while (!o_cmd_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_rdy", {63'd0, o_cmd_rdy}, 64'd1);
        i_cmd_vld  = 1'b1;
        i_cmd_wr   = wr;
        i_cmd_addr = addr;
        i_cmd_len  = len;
        @(posedge clk);
        #1 i_cmd_vld = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [3:0] kind,
                            input logic [63:0] addr, input logic [9:0] len);
        int n = 0;
        @(negedge clk);
        while (reqvec == 4'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_kind"}, {60'd0, reqvec}, {60'd0, kind});
        chk({tag, "_addr"}, o_req_addr, addr);
        chk({tag, "_len"}, {54'd0, o_req_length}, {54'd0, len});
    endtask

    task automatic ack_req(input string tag, input logic [3:0] kind, input logic last);
        {i_mrd64_req_ack, i_mrd32_req_ack, i_mwr64_req_ack, i_mwr32_req_ack} = kind;
        @(posedge clk);
        #1 {i_mrd64_req_ack, i_mrd32_req_ack, i_mwr64_req_ack, i_mwr32_req_ack} = 4'd0;
        @(negedge clk);
        chk({tag, "_drop"}, {60'd0, reqvec}, 64'd0);
        chk({tag, "_done"}, {63'd0, o_cmd_done}, {63'd0, last});
    endtask

    task automatic finish_cmd(input string tag);
        @(negedge clk);
        chk({tag, "_done_off"}, {63'd0, o_cmd_done}, 64'd0);
        chk({tag, "_busy_off"}, {63'd0, o_busy}, 64'd0);
        chk({tag, "_rdy_on"}, {63'd0, o_cmd_rdy}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {63'd0, o_cmd_rdy}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_done", {63'd0, o_cmd_done}, 64'd0);
        chk("rst_req", {60'd0, reqvec}, 64'd0);
        chk("rst_len", {54'd0, o_req_length}, 64'd0);
        chk("rst_addr", o_req_addr, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy_low", {63'd0, o_cmd_rdy}, 64'd0);
        @(negedge clk);
        chk("rel_rdy_high", {63'd0, o_cmd_rdy}, 64'd1);

        // write 0x1000 len 100, MPS 128B
        i_cfg_max_payload_size = 3'd0;
        issue(1'b1, 64'h1000, 16'd100);
        @(negedge clk);
        chk("t1_calc_busy", {63'd0, o_busy}, 64'd1);
        chk("t1_calc_rdy", {63'd0, o_cmd_rdy}, 64'd0);
        chk("t1_calc_req", {60'd0, reqvec}, 64'd0);
        @(negedge clk);
        chk("t1_c0_kind", {60'd0, reqvec}, 64'd1);
        chk("t1_c0_addr", o_req_addr, 64'h1000);
        chk("t1_c0_len", {54'd0, o_req_length}, 64'd32);
        i_mrd32_req_ack = 1'b1;
        @(posedge clk);
        #1 i_mrd32_req_ack = 1'b0;
        @(negedge clk);
        chk("t1_badack", {60'd0, reqvec}, 64'd1);
        ack_req("t1_c0", 4'b0001, 1'b0);
        wait_req("t1_c1", 4'b0001, 64'h1080, 10'd32);
        ack_req("t1_c1", 4'b0001, 1'b0);
        wait_req("t1_c2", 4'b0001, 64'h1100, 10'd32);
        ack_req("t1_c2", 4'b0001, 1'b0);
        wait_req("t1_c3", 4'b0001, 64'h1180, 10'd4);
        ack_req("t1_c3", 4'b0001, 1'b1);
        finish_cmd("t1");

        // read across a 4 KB page, MRRS 512B; config change after accept must not matter
        i_cfg_max_rd_req_size = 3'd2;
        issue(1'b0, 64'h1_0000_0F80, 16'd64);
        i_cfg_max_rd_req_size = 3'd0;
`ifdef IPS2L_PCIE_DMA_4K_SPLIT_EN
        wait_req("t2_c0", 4'b1000, 64'h1_0000_0F80, 10'd32);
        repeat (2) @(negedge clk);
        chk("t2_hold_req", {60'd0, reqvec}, 64'h8);
        chk("t2_hold_addr", o_req_addr, 64'h1_0000_0F80);
        ack_req("t2_c0", 4'b1000, 1'b0);
        wait_req("t2_c1", 4'b1000, 64'h1_0000_1000, 10'd32);
        ack_req("t2_c1", 4'b1000, 1'b1);
`else
        wait_req("t2_c0", 4'b1000, 64'h1_0000_0F80, 10'd64);
        repeat (2) @(negedge clk);
        chk("t2_hold_req", {60'd0, reqvec}, 64'h8);
        chk("t2_hold_len", {54'd0, o_req_length}, 64'd64);
        ack_req("t2_c0", 4'b1000, 1'b1);
`endif
        finish_cmd("t2");

        // 1024 DW write, MPS 4096B, held off by write busy first
        i_cfg_max_payload_size = 3'd5;
        i_mwr_tx_busy = 1'b1;
        issue(1'b1, 64'h0, 16'd1024);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_busy_gate", {60'd0, reqvec}, 64'd0);
        end
        @(posedge clk);
        #1 i_mwr_tx_busy = 1'b0;
        wait_req("t3_c0", 4'b0001, 64'h0, 10'd0);
        ack_req("t3_c0", 4'b0001, 1'b1);
        finish_cmd("t3");

        // read with tag-full back-pressure after the first ack
        i_cfg_max_rd_req_size = 3'd0;
        issue(1'b0, 64'h2000, 16'd64);
        wait_req("t4_c0", 4'b0100, 64'h2000, 10'd32);
        i_mrd32_req_ack = 1'b1;
        @(posedge clk);
        #1 i_mrd32_req_ack = 1'b0;
        i_tag_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_tag_gate", {60'd0, reqvec}, 64'd0);
        end
        @(posedge clk);
        #1 i_tag_full = 1'b0;
        @(negedge clk);
        chk("t4_pre_rise", {60'd0, reqvec}, 64'd0);
        @(negedge clk);
        chk("t4_c1_kind", {60'd0, reqvec}, 64'h4);
        chk("t4_c1_addr", o_req_addr, 64'h2080);
        chk("t4_c1_len", {54'd0, o_req_length}, 64'd32);
        ack_req("t4_c1", 4'b0100, 1'b1);
        finish_cmd("t4");

        // zero-length write
        issue(1'b1, 64'h4000, 16'd0);
        @(negedge clk);
        chk("t5_zero_done", {63'd0, o_cmd_done}, 64'd1);
        chk("t5_zero_req", {60'd0, reqvec}, 64'd0);
        finish_cmd("t5_zero");

        // reserved MPS encoding falls back to 32 DW
        i_cfg_max_payload_size = 3'd7;
        issue(1'b1, 64'h3000, 16'd40);
        wait_req("t5_c0", 4'b0001, 64'h3000, 10'd32);
        ack_req("t5_c0", 4'b0001, 1'b0);
        wait_req("t5_c1", 4'b0001, 64'h3080, 10'd8);
        ack_req("t5_c1", 4'b0001, 1'b1);
        finish_cmd("t5");

        // reset while an MWr64 request is high
        i_cfg_max_payload_size = 3'd0;
        issue(1'b1, 64'h2_0000_0000, 16'd16);
        wait_req("t6_c0", 4'b0010, 64'h2_0000_0000, 10'd16);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_req", {60'd0, reqvec}, 64'd0);
        chk("t6_rst_busy", {63'd0, o_busy}, 64'd0);
        chk("t6_rst_addr", o_req_addr, 64'd0);
        chk("t6_rst_done", {63'd0, o_cmd_done}, 64'd0);
        chk("t6_rst_rdy", {63'd0, o_cmd_rdy}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rel_rdy_low", {63'd0, o_cmd_rdy}, 64'd0);
        chk("t6_rel_done", {63'd0, o_cmd_done}, 64'd0);
        @(negedge clk);
        chk("t6_rel_rdy_high", {63'd0, o_cmd_rdy}, 64'd1);
        chk("t6_rel_busy", {63'd0, o_busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ips2l_pcie_dma_req_splitter.md
# ips2l_pcie_dma_req_splitter

DMA command splitter sitting directly upstream of the PCIe DMA TX path. It accepts one DMA transfer command (address, length in DW, direction) and cuts it into TLP-sized requests. Each request is bounded by max payload size for writes and by max read request size for reads. It drives the MWr32/MWr64/MRd32/MRd64 request/ack handshakes plus `req_length`/`req_addr` of the TX top, and honours its busy and tag-full back-pressure.

## Interface
Parameters:
- `CMD_LEN_WIDTH`, 16, width of command length in DW (max 2^16-1 DW).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  core user clock (gen1 62.5 MHz, gen2 125 MHz)
- `rst_n`  in  1  synchronous active-low reset
- `i_cfg_max_payload_size`  in  3  MPS encoding (0=128B … 5=4096B)
- `i_cfg_max_rd_req_size`  in  3  MRRS encoding, same coding
- `i_cmd_vld`  in  1  command valid
- `o_cmd_rdy`  out  1  command ready
- `i_cmd_wr`  in  1  1 = write (MWr), 0 = read (MRd)
- `i_cmd_addr`  in  64  start byte address; bits[1:0] ignored
- `i_cmd_len`  in  CMD_LEN_WIDTH  transfer length in DW
- `o_cmd_done`  out  1  one-cycle pulse after the last request is acked
- `o_busy`  out  1  high from accept until done
- `o_mwr32_req` / `i_mwr32_req_ack`, `o_mwr64_req` / `i_mwr64_req_ack`  out/in  1  write request handshakes
- `o_mrd32_req` / `i_mrd32_req_ack`, `o_mrd64_req` / `i_mrd64_req_ack`  out/in  1  read request handshakes
- `o_req_length`  out  10  chunk length in DW; 0 encodes 1024
- `o_req_addr`  out  64  chunk start address, bits[1:0]=0
- `i_mwr_tx_busy`  in  1  write path busy; blocks write issue
- `i_tag_full`  in  1  no free read tag; blocks read issue

## Operation
- States:
  - IDLE: `o_cmd_rdy`=1. On `vld&rdy`, latch addr, len, dir and the relevant size encoding.
    - len=0 → DONE.
    - Otherwise → CALC.
  - CALC: registers chunk = min(remaining, max_dw, dw_to_4k). Then:
    - → HOLD if gated.
    - → REQ if not gated.
  - HOLD: waits until the gate is clear.
    - Write gate: `i_mwr_tx_busy`.
    - Read gate: `i_tag_full`.
  - REQ: exactly one of the four requests is held high until its ack is sampled. On ack:
    - addr += chunk*4, remaining -= chunk.
    - remaining=0 → DONE; otherwise → CALC.
  - DONE: `o_cmd_done`=1 for one cycle → IDLE.
- Chunk sizing:
  - max_dw = 32 << enc. Encodings 6 and 7 are treated as 0 (32 DW).
  - dw_to_4k = 1024 − addr[11:2]; it applies only with the macro enabled (see Configuration).
  - A chunk of 1024 DW is output as `o_req_length`=0.
- 32/64 select: per chunk.
  - Start addr[63:32]==0 → 32-bit variant.
  - Otherwise → 64-bit variant.
- Address arithmetic is 64-bit modulo 2^64; remaining is CMD_LEN_WIDTH bits and never underflows, because chunk ≤ remaining.
- Config inputs changing mid-command have no effect; the encodings are latched at accept.
- Acks that arrive outside REQ, or that do not match the asserted request, are ignored.

## Timing
- Reset values: all `o_*req`=0, `o_cmd_rdy`=0, `o_cmd_done`=0, `o_busy`=0, `o_req_length`=0, `o_req_addr`=0.
- `o_cmd_rdy` rises one cycle after `rst_n` deasserts.
- Accept at cycle N:
  - CALC at N+1.
  - Request high at N+2 if ungated.
  - `o_busy` high from N+1.
- `o_req_length`/`o_req_addr` are valid from the cycle the request rises and stable while it is high.
- Ack sampled at cycle M:
  - Request low at M+1; CALC at M+1.
  - Next request at M+2 at the earliest.
  - Or, if this was the last chunk: `o_cmd_done` at M+1, `o_busy` low and `o_cmd_rdy` high at M+2.
- Gate sampled in CALC/HOLD only. A gate rising while a request is already high does not retract the request.
- len=0: `o_cmd_done` at N+1, no request.
- `rst_n` low on any edge mid-command: all outputs return to reset values the next cycle, with no done pulse; the command is dropped.

## Configuration
- Macro `IPS2L_PCIE_DMA_4K_SPLIT_EN`.
- Defined: chunks never cross a 4 KB address boundary (dw_to_4k term active).
- Undefined: the 4 KB term is removed and chunks are bounded only by MPS/MRRS and remaining length; callers guarantee boundary compliance.

## Test plan
- Write, addr 0x1000, len 100, MPS enc 0 → four MWr32 requests (0x1000,32), (0x1080,32), (0x1100,32), (0x1180,4); one `o_cmd_done`.
- Read, addr 0x1_0000_0F80, len 64, MRRS enc 2:
  - With the macro → MRd64 (0x1_0000_0F80,32) then (0x1_0000_1000,32).
  - Without the macro → a single MRd64 of length 64.
- Write, addr 0, len 1024, MPS enc 5 → one MWr32 with `o_req_length`=0.
- Read, len 64, MRRS enc 0, `i_tag_full` high for 10 cycles after the first ack:
  - Second request stays low throughout.
  - Second request rises 1 cycle after `i_tag_full` falls.
- len=0 write → `o_cmd_done` at N+1, no request asserted. MPS enc 7 with len 40 → chunks of 32 and 8.
- `rst_n` pulled low while `o_mwr64_req` is high → request, `o_busy` and `o_req_addr` are 0 the next cycle; no `o_cmd_done`; `o_cmd_rdy` returns 1 cycle after release.
